// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter.
// Pulls the clock low to request to send, then shifts out the start bit,
// eight data bits (LSB first), odd parity and the stop bit on the falling edges
// of the device clock. It then samples the device acknowledge bit.
// It shares the open-drain pins with the scan-code receiver. rx_en keeps that
// receiver quiet while a transfer is in flight.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       rx_en,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    // S_DONE is a one-cycle state that carries tx_done_tick. The block is
    // therefore not yet idle when the tick is visible, so a write in that
    // cycle is dropped.
    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_START,
        S_DATA,
        S_STOP,
        S_ACK,
        S_WAITREL,
        S_DONE
    } state_t;

    logic [1:0]            r_c_sync;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_filt_val;
    logic                  w_filt_val_next;
    logic                  w_c_s;
    logic                  w_d_s;
    logic                  w_fall;

    state_t                r_state;
    state_t                w_state_next;
    logic [8:0]            r_tx_shift;
    logic [8:0]            w_tx_shift_next;
    logic [3:0]            r_n;
    logic [3:0]            w_n_next;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         w_timer_next;
    logic                  r_err;
    logic                  w_err_next;

    assign w_c_s = r_c_sync[1];
    assign w_d_s = r_d_sync[1];

    // Two-flop synchronisers for the asynchronous pins; they idle high like the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
        end else begin
            r_c_sync <= {r_c_sync[0], ps2c_in};
            r_d_sync <= {r_d_sync[0], ps2d_in};
        end
    end

    // The filtered clock level changes only after FILTER_LEN identical samples.
    always_comb begin
        w_filt_val_next = r_filt_val;
        if (&r_filt)
            w_filt_val_next = 1'b1;
        else if (~|r_filt)
            w_filt_val_next = 1'b0;
    end

    assign w_fall = r_filt_val & ~w_filt_val_next;

    // Clock glitch filter shift register and filtered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt     <= '1;
            r_filt_val <= 1'b1;
        end else begin
            r_filt     <= {r_filt[FILTER_LEN-2:0], w_c_s};
            r_filt_val <= w_filt_val_next;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx_shift <= '0;
            r_n        <= '0;
            r_timer    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tx_shift <= w_tx_shift_next;
            r_n        <= w_n_next;
            r_timer    <= w_timer_next;
            r_err      <= w_err_next;
        end
    end

    // Next-state logic. The frame states share the inter-edge timeout.
    always_comb begin
        w_state_next    = r_state;
        w_tx_shift_next = r_tx_shift;
        w_n_next        = r_n;
        w_timer_next    = r_timer;
        w_err_next      = r_err;

        unique case (r_state)
            S_IDLE: begin
                if (wr_ps2) begin
                    w_tx_shift_next = {~^din, din};
                    w_err_next      = 1'b0;
                    w_timer_next    = '0;
                    w_state_next    = S_RTS;
                end
            end
            S_RTS: begin
                if (r_timer == INHIBIT_LAST) begin
                    w_timer_next = '0;
                    w_state_next = S_START;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                // START, DATA, STOP, ACK, WAITREL
                w_timer_next = w_fall ? '0 : r_timer + 1'b1;
                case (r_state)
                    S_START: begin
                        if (w_fall) begin
                            w_n_next     = 4'd8;
                            w_state_next = S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_fall) begin
                            w_tx_shift_next = {1'b1, r_tx_shift[8:1]};
                            if (r_n == 4'd0)
                                w_state_next = S_STOP;
                            else
                                w_n_next = r_n - 4'd1;
                        end
                    end
                    S_STOP: begin
                        if (w_fall)
                            w_state_next = S_ACK;
                    end
                    S_ACK: begin
                        if (w_fall) begin
                            w_err_next   = w_d_s;
                            w_state_next = S_WAITREL;
                        end
                    end
                    S_WAITREL: begin
                        if (r_filt_val && w_d_s)
                            w_state_next = S_DONE;
                    end
                    default: ;
                endcase
                // A normal exit in the same cycle takes precedence over the abort.
                if (w_state_next == r_state && !w_fall && r_timer == TIMEOUT_LAST) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_DONE;
                end
            end
        endcase
    end

    // Moore output decodes. The data line is only pulled once the clock is released.
    always_comb begin
        ps2c_oe      = (r_state == S_RTS);
        ps2d_oe      = (r_state == S_START) || ((r_state == S_DATA) && !r_tx_shift[0]);
        tx_idle      = (r_state == S_IDLE);
        rx_en        = (r_state == S_IDLE);
        tx_done_tick = (r_state == S_DONE);
        tx_err       = r_err;
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a simple PS/2 device model on an
// open-drain bus. The model uses a 20-cycle clock half-period, samples the data
// line at the end of each clock-high phase and drives the acknowledge bit.
module tb_ps2_transmitter;

    localparam int INH  = 50;
    localparam int TMO  = 2000;
    localparam int FL   = 8;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_oe, ps2d_oe, tx_idle, rx_en, tx_done_tick, tx_err;
    logic       dev_c_low, dev_d_low;
    logic       glitch_en;
    logic       ps2c_line, ps2d_line;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    assign ps2c_line = ~(ps2c_oe | dev_c_low);
    assign ps2d_line = ~(ps2d_oe | dev_d_low);

    ps2_transmitter #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c_in     (ps2c_line),
        .ps2d_in     (ps2d_line),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .tx_idle     (tx_idle),
        .rx_en       (rx_en),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [7:0]  din;
        logic        ack;    // 0 = device acknowledges, 1 = NACK
        logic [10:0] frame;  // {stop, parity, d7..d0, start}
        logic        err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic dev_half_high();
        for (int c = 0; c < HALF; c++) begin
            dev_c_low = glitch_en && (c >= 12) && (c < 15);
            @(negedge clk);
        end
        dev_c_low = 1'b0;
    endtask

    task automatic dev_half_low();
        dev_c_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_c_low = 1'b0;
    endtask

    // Host write; checks that RTS is entered on the next cycle.
    task automatic start_send(input logic [7:0] b, input logic hold);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        if (!hold) wr_ps2 = 1'b0;
        check("accept_rts", {30'd0, tx_idle, ps2c_oe}, 32'b01);
    endtask

    // Device side of a frame. It measures the RTS hold and clocks out the bits.
    // If stop_after is at most 10, it gives up after that many falling edges.
    task automatic dev_frame(input logic ack_bit, input int stop_after,
                             output logic [10:0] frame, output int rts_len);
        frame   = '0;
        rts_len = 0;
        while (ps2c_oe && rts_len < 200) begin
            rts_len++;
            @(negedge clk);
        end
        check("start_bit_driven", {31'd0, ps2d_oe}, 32'd1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (i == stop_after) return;
            dev_half_high();
            frame[i] = ps2d_line;
            dev_half_low();
        end
        dev_d_low = ~ack_bit;
        dev_half_high();
        dev_half_low();
        repeat (2) @(negedge clk);
        dev_d_low = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!tx_done_tick && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        check("done_seen", {31'd0, tx_done_tick}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] frame;
        int          rts;
        int          cyc;
        int          base;

        vecs[0] = '{8'hED, 1'b0, 11'h7DA, 1'b0};
        vecs[1] = '{8'hF4, 1'b1, 11'h5E8, 1'b1};
        vecs[2] = '{8'hA5, 1'b0, 11'h74A, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 11'h500, 1'b1};
        vecs[4] = '{8'h3C, 1'b0, 11'h678, 1'b0};

        rst = 1'b1; wr_ps2 = 1'b0; din = 8'h00;
        dev_c_low = 1'b0; dev_d_low = 1'b0; glitch_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {26'd0, ps2c_oe, ps2d_oe, tx_idle, rx_en, tx_done_tick, tx_err}, 32'b001100);
        $display("reset: outputs c_oe=%b d_oe=%b idle=%b rx_en=%b done=%b err=%b",
                 ps2c_oe, ps2d_oe, tx_idle, rx_en, tx_done_tick, tx_err);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Table-driven full frames
        for (int v = 0; v < 5; v++) begin
            base = done_cnt;
            start_send(vecs[v].din, 1'b0);
            dev_frame(vecs[v].ack, 99, frame, rts);
            check("rts_len", rts, INH);
            check("frame", {21'd0, frame}, {21'd0, vecs[v].frame});
            wait_done(cyc);
            check("tx_err", {31'd0, tx_err}, {31'd0, vecs[v].err});
            check("lines_released_at_done", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
            @(negedge clk);
            check("rx_en_after_done", {31'd0, rx_en}, 32'd1);
            @(negedge clk);
            check("one_done_tick", done_cnt - base, 1);
            $display("vec %0d: din=%h ack=%b frame=%h rts=%0d err=%b", v, vecs[v].din,
                     vecs[v].ack, frame, rts, tx_err);
            repeat (10) @(negedge clk);
        end

        // Device never clocks: timeout measured from the first START cycle
        base = done_cnt;
        start_send(8'hF4, 1'b0);
        cyc = 0;
        while (ps2c_oe && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("timeout_rts_len", cyc, INH);
        cyc = 0;
        while (!tx_done_tick && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, TMO);
        check("timeout_err", {31'd0, tx_err}, 32'd1);
        check("timeout_lines", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
        @(negedge clk);
        check("timeout_rx_en", {31'd0, rx_en}, 32'd1);
        @(negedge clk);
        check("timeout_one_tick", done_cnt - base, 1);
        $display("timeout: done after %0d cycles err=%b", cyc, tx_err);
        repeat (10) @(negedge clk);

        // Reset during DATA bit 4, with a write that reset must override
        base = done_cnt;
        start_send(8'hA5, 1'b0);
        dev_frame(1'b0, 5, frame, rts);
        check("data_bit4_driven", {31'd0, ps2d_oe}, 32'd1);
        rst = 1'b1;
        wr_ps2 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr_ps2 = 1'b0;
        check("rst_mid_transfer", {29'd0, ps2c_oe, ps2d_oe, tx_idle}, 32'b001);
        repeat (2500) @(negedge clk);
        check("rst_no_done_tick", done_cnt - base, 0);
        $display("reset mid-frame: idle=%b ticks=%0d", tx_idle, done_cnt - base);
        base = done_cnt;
        start_send(8'hFF, 1'b0);
        dev_frame(1'b0, 99, frame, rts);
        check("after_rst_frame", {21'd0, frame}, 32'h7FE);
        wait_done(cyc);
        check("after_rst_err", {31'd0, tx_err}, 32'd0);
        repeat (2) @(negedge clk);
        check("after_rst_one_tick", done_cnt - base, 1);
        $display("send FF after reset: frame=%h err=%b", frame, tx_err);
        repeat (10) @(negedge clk);

        // wr_ps2 held through the whole 0x00 transfer, 3-cycle clock glitches injected
        glitch_en = 1'b1;
        base = done_cnt;
        start_send(8'h00, 1'b1);
        dev_frame(1'b0, 99, frame, rts);
        check("held_rts_len", rts, INH);
        check("held_frame", {21'd0, frame}, 32'h600);
        wait_done(cyc);
        check("held_err", {31'd0, tx_err}, 32'd0);
        @(negedge clk);
        check("wr_in_tick_cycle_ignored", {31'd0, tx_idle}, 32'd1);
        wr_ps2 = 1'b0;
        @(negedge clk);
        check("held_stays_idle", {31'd0, tx_idle}, 32'd1);
        check("held_one_tick", done_cnt - base, 1);
        glitch_en = 1'b0;
        $display("held wr 00 with glitches: frame=%h err=%b ticks=%0d", frame, tx_err,
                 done_cnt - base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
